// File: rtl/spi_pkg.sv
// Shared types, constants and helpers for the SPI responder and its synchronizer.
package spi_pkg;

  localparam int unsigned SPI_MAXLEN_DEF = 16;
  localparam logic        SPI_CPOL       = 1'b0;
  localparam logic        SPI_CPHA       = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } spi_state_t;

  // A zero or oversize request means a full-length frame.
  function automatic int unsigned eff_len(input int unsigned n_bits,
                                          input int unsigned max_len);
    if (n_bits == 32'd0 || n_bits > max_len) begin
      return max_len;
    end else begin
      return n_bits;
    end
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for an asynchronous pin with registered rise/fall pulses.
module spi_sync
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;
  logic fall_q;

  // Synchronizer chain and edge pulses; pulses appear 3 cycles after the pin moves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples SCLK/CS_N/MOSI in the clk domain, shifts
// MSB-first frames of up to SPI_MAXLEN bits, drives MISO from a holding register.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned SPI_MAXLEN = SPI_MAXLEN_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(SPI_MAXLEN):0] n_bits,
  input  logic                        sclk,
  input  logic                        cs_n,
  input  logic                        mosi,
  output logic                        miso,
  input  logic [SPI_MAXLEN-1:0]       tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [SPI_MAXLEN-1:0]       rx_data,
  output logic                        rx_valid,
  output logic                        busy,
  output logic                        frame_err,
  output logic                        tx_underrun
);

  localparam int CW = $clog2(SPI_MAXLEN) + 1;
  localparam int IW = $clog2(SPI_MAXLEN);

  spi_state_t            state_q, state_d;
  logic [CW-1:0]         len_q, len_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [SPI_MAXLEN-1:0] tx_shift_q, tx_shift_d;
  logic [SPI_MAXLEN-1:0] rx_shift_q, rx_shift_d;
  logic [SPI_MAXLEN-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  miso_q, miso_d;
  logic [SPI_MAXLEN-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  busy_q;
  logic                  frame_err_q, frame_err_d;
  logic                  tx_underrun_q, tx_underrun_d;
  logic                  mosi_meta_q, mosi_sync_q;

  logic                  sclk_lvl_s, sclk_rise_s, sclk_fall_s;
  logic                  cs_lvl_s, cs_rise_s, cs_fall_s;
  logic                  shift_edge_s, drive_edge_s;
  logic                  load_s;
  logic [CW-1:0]         start_len_s, start_idx_s, next_idx_s;
  logic [SPI_MAXLEN-1:0] start_word_s, rx_mask_s;
  logic                  unused_s;

  spi_sync #(.RST_VAL(SPI_CPOL)) u_sclk_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (sclk),
    .sync_o  (sclk_lvl_s),
    .rise_o  (sclk_rise_s),
    .fall_o  (sclk_fall_s)
  );

  spi_sync #(.RST_VAL(1'b1)) u_cs_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (cs_n),
    .sync_o  (cs_lvl_s),
    .rise_o  (cs_rise_s),
    .fall_o  (cs_fall_s)
  );

  // MOSI needs only the level path; it is sampled on the shift edge pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      mosi_meta_q <= mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign shift_edge_s = (SPI_CPHA == 1'b0) ? sclk_rise_s : sclk_fall_s;
  assign drive_edge_s = (SPI_CPHA == 1'b0) ? sclk_fall_s : sclk_rise_s;
  assign load_s       = tx_valid && !hold_full_q;
  assign start_len_s  = CW'(eff_len(32'(n_bits), SPI_MAXLEN));
  assign start_idx_s  = start_len_s - CW'(1);
  assign next_idx_s   = len_q - bit_cnt_q - CW'(1);
  assign start_word_s = hold_full_q ? hold_q : (load_s ? tx_data : '0);
  assign unused_s     = ^{sclk_lvl_s, cs_lvl_s, start_idx_s[CW-1], next_idx_s[CW-1]};

  // Mask that keeps only the low len_q bits of the received word.
  always_comb begin
    rx_mask_s = '0;
    for (int unsigned i = 0; i < SPI_MAXLEN; i++) begin
      rx_mask_s[i] = (i < 32'(len_q));
    end
  end

  // Next-state and datapath decisions.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    bit_cnt_d     = bit_cnt_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    miso_d        = miso_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_err_d   = 1'b0;
    tx_underrun_d = 1'b0;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;

    if (load_s) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end else begin
      hold_d      = hold_q;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall_s) begin
          state_d       = ACTIVE;
          len_d         = start_len_s;
          bit_cnt_d     = '0;
          rx_shift_d    = '0;
          tx_shift_d    = start_word_s;
          hold_full_d   = 1'b0;
          tx_underrun_d = !hold_full_q && !load_s;
          miso_d        = start_word_s[start_idx_s[IW-1:0]];
        end else begin
          miso_d        = 1'b0;
        end
      end
      ACTIVE: begin
        // A chip-select release wins over any coincident clock edge.
        if (cs_rise_s) begin
          miso_d = 1'b0;
          if (bit_cnt_q == len_q) begin
            state_d    = DONE;
            rx_data_d  = rx_shift_q & rx_mask_s;
            rx_valid_d = 1'b1;
          end else begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
          end
        end else if (shift_edge_s) begin
          if (bit_cnt_q < len_q) begin
            rx_shift_d = {rx_shift_q[SPI_MAXLEN-2:0], mosi_sync_q};
            bit_cnt_d  = bit_cnt_q + CW'(1);
          end else begin
            bit_cnt_d  = len_q;
          end
        end else if (drive_edge_s) begin
          if (bit_cnt_q < len_q) begin
            miso_d = tx_shift_q[next_idx_s[IW-1:0]];
          end else begin
            miso_d = 1'b0;
          end
        end else begin
          miso_d = miso_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        miso_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        miso_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      len_q         <= '0;
      bit_cnt_q     <= '0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      miso_q        <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      miso_q        <= miso_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      busy_q        <= (state_d == ACTIVE);
      frame_err_q   <= frame_err_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign miso        = miso_q;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = busy_q;
  assign frame_err   = frame_err_q;
  assign tx_underrun = tx_underrun_q;

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder for the far end of the team's SPI master link. It samples the master's SCLK, CS_N and MOSI in the system clock domain and shifts a frame of up to SPI_MAXLEN bits MSB-first in SPI mode 0 (CPOL=0, CPHA=0). It drives MISO from a loaded transmit word and presents each received word on a parallel port with a one-cycle valid strobe. It is the peer of the master-side clock divider and shifter, and uses the same SPI_MAXLEN and bit-count width conventions.

## Interface
- SPI_MAXLEN, 16: maximum frame length in bits.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-low.
- n_bits  in  $clog2(SPI_MAXLEN)+1  frame length; sampled at frame start; 0 or >SPI_MAXLEN means SPI_MAXLEN.
- sclk  in  1  SPI clock from master, asynchronous to clk.
- cs_n  in  1  chip select, active-low, asynchronous.
- mosi  in  1  master-out data, asynchronous.
- miso  out  1  slave-out data.
- tx_data  in  SPI_MAXLEN  word to send, right-aligned; bit n_bits-1 is sent first.
- tx_valid  in  1  tx_data offered.
- tx_ready  out  1  holding register empty; a load occurs when tx_valid && tx_ready.
- rx_data  out  SPI_MAXLEN  last received word, right-aligned, upper bits zero.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  high in ACTIVE.
- frame_err  out  1  one-cycle pulse on abort.
- tx_underrun  out  1  one-cycle pulse when a frame starts with no word loaded.

## Operation
- sclk, cs_n and mosi each pass through a 2-flop synchronizer. sclk and cs_n also get a registered edge detector.
- States:
  - IDLE: waits for a cs_n fall.
  - ACTIVE: shifts bits.
  - DONE: 1 cycle; publishes rx, then goes to IDLE.
- IDLE → ACTIVE on a detected cs_n fall. On that cycle:
  - latch the effective length into len, clear bit_cnt to 0.
  - copy the holding register into tx_shift, or zeros if it is empty. The empty case pulses tx_underrun.
  - drive miso from bit len-1.
- ACTIVE, sclk rise: shift the synchronized mosi into rx_shift LSB; bit_cnt += 1.
- ACTIVE, sclk fall with bit_cnt < len: drive miso from the next tx bit.
- ACTIVE, sclk fall with bit_cnt == len: drive miso 0.
- ACTIVE → DONE when bit_cnt == len and cs_n rise is detected. Rise edges beyond len are ignored and bit_cnt saturates at len.
- ACTIVE → IDLE on cs_n rise with bit_cnt < len: pulse frame_err, leave rx_data unchanged, no rx_valid.
- DONE: rx_data <= rx_shift masked to len bits; rx_valid=1.
- tx_ready = holding register empty. It is set at reset and when the word is consumed at frame start. A load on the same cycle as the consuming cs_n fall is taken for the current frame.
- sclk edges while cs_n is high are ignored. miso is 0 outside ACTIVE.

## Timing
- Reset values: miso 0, rx_data 0, rx_valid 0, busy 0, frame_err 0, tx_underrun 0, tx_ready 1, state IDLE.
- Reset asserted mid-frame aborts immediately. No frame_err is issued and the holding register is cleared.
- Input-to-action latency: 3 clk cycles (2 sync + 1 edge register) from a pin transition to the internal edge pulse. miso updates 1 cycle after that.
- Master requirements:
  - SCLK high and low phases ≥ 4 clk periods each.
  - cs_n fall to first sclk rise ≥ 4 clk periods.
  - last sclk fall to cs_n rise ≥ 4 clk periods.
- rx_valid asserts 4 clk cycles after the cs_n pin rise: 3 cycles edge detect + 1 cycle DONE.
- busy asserts the cycle after the cs_n fall is detected and deasserts on leaving ACTIVE.
- Widths:
  - bit_cnt and len are $clog2(SPI_MAXLEN)+1 bits.
  - len clamp: n_bits==0 || n_bits>SPI_MAXLEN → SPI_MAXLEN.

## Structure
- Package spi_pkg holds:
  - spi_state_t enum (IDLE, ACTIVE, DONE);
  - localparam SPI_CPOL=0, SPI_CPHA=0;
  - helper function eff_len(n_bits, SPI_MAXLEN) for the clamp.
- Sub-module spi_sync: 2-flop synchronizer plus rise/fall pulse outputs. It is instantiated for sclk and cs_n; mosi uses the synchronizer path only.

## Test plan
- Load tx_data=16'hA55A, n_bits=16, master sends 16'h3C96 at sclk = clk/8 → miso stream A55A MSB-first, rx_data=16'h3C96, one rx_valid pulse, tx_ready re-asserts at frame start.
- n_bits=5, tx_data=5'b10011, master sends 5'b01101 → miso 1,0,0,1,1; rx_data=16'h000D.
- cs_n rises after 7 of 16 bits → frame_err pulse, no rx_valid, rx_data keeps its previous value, state IDLE.
- Frame started with no tx word loaded → tx_underrun pulse, miso all 0, rx still captured correctly.
- Master clocks 20 edges with n_bits=16 → only the first 16 bits are captured, miso 0 for the extra bits, rx_valid once.
- rst asserted mid-frame → all outputs at reset values in the same cycle; the next full frame completes normally.
